// File: rtl/uart_cmd_parser.sv
// UART command frame decoder: SYNC OPC DHI DLO CHK -> cmd_opcode/cmd_data strobe.
// Optional ACK/NAK response path enabled by defining UART_CMD_ECHO_EN.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned TO_W        = 17,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [3:0]  cmd_opcode,
  output logic [15:0] cmd_data,
  output logic        cmd_dat_update,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_DHI, S_DLO, S_CHK
`ifdef UART_CMD_ECHO_EN
    , S_RESP
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      opc_q, opc_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [3:0]      cmd_opcode_q, cmd_opcode_d;
  logic [15:0]     cmd_data_q, cmd_data_d;
  logic            upd_q, upd_d;
  logic [7:0]      err_q, err_d;
  logic            err_inc;
  logic            frame_ok;
  logic            timeout;
`ifdef UART_CMD_ECHO_EN
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
`endif

  assign frame_ok = (opc_q[7:4] == 4'h0) && ((opc_q ^ dhi_q ^ dlo_q) == rx_data);
  assign timeout  = (to_q == TO_W'(TIMEOUT_CYC));

  // Next-state, frame capture and error accounting; timeout beats a same-cycle byte.
  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    dhi_d        = dhi_q;
    dlo_d        = dlo_q;
    to_d         = to_q;
    cmd_opcode_d = cmd_opcode_q;
    cmd_data_d   = cmd_data_q;
    upd_d        = 1'b0;
    err_inc      = 1'b0;
`ifdef UART_CMD_ECHO_EN
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        to_d = '0;
        if (rx_valid && rx_data == SYNC_BYTE) state_d = S_OPC;
      end
      S_OPC, S_DHI, S_DLO, S_CHK: begin
        if (timeout) begin
          state_d = S_IDLE;
          to_d    = '0;
          err_inc = 1'b1;
        end else if (rx_valid) begin
          to_d = '0;
          case (state_q)
            S_OPC: begin opc_d = rx_data; state_d = S_DHI; end
            S_DHI: begin dhi_d = rx_data; state_d = S_DLO; end
            S_DLO: begin dlo_d = rx_data; state_d = S_CHK; end
            default: begin
              if (frame_ok) begin
                cmd_opcode_d = opc_q[3:0];
                cmd_data_d   = {dhi_q, dlo_q};
                upd_d        = 1'b1;
              end else begin
                err_inc = 1'b1;
              end
`ifdef UART_CMD_ECHO_EN
              tx_valid_d = 1'b1;
              tx_data_d  = frame_ok ? ACK_BYTE : NAK_BYTE;
              state_d    = S_RESP;
`else
              state_d    = S_IDLE;
`endif
            end
          endcase
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
`ifdef UART_CMD_ECHO_EN
      S_RESP: begin
        to_d = '0;
        if (rx_valid) err_inc = 1'b1;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      opc_q        <= '0;
      dhi_q        <= '0;
      dlo_q        <= '0;
      to_q         <= '0;
      cmd_opcode_q <= '0;
      cmd_data_q   <= '0;
      upd_q        <= 1'b0;
      err_q        <= '0;
`ifdef UART_CMD_ECHO_EN
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      dhi_q        <= dhi_d;
      dlo_q        <= dlo_d;
      to_q         <= to_d;
      cmd_opcode_q <= cmd_opcode_d;
      cmd_data_q   <= cmd_data_d;
      upd_q        <= upd_d;
      err_q        <= err_d;
`ifdef UART_CMD_ECHO_EN
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
`endif
    end
  end

  assign cmd_opcode     = cmd_opcode_q;
  assign cmd_data       = cmd_data_q;
  assign cmd_dat_update = upd_q;
  assign err_cnt        = err_q;
`ifdef UART_CMD_ECHO_EN
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;
`else
  logic unused_tx;
  assign unused_tx = ^{tx_ready, ACK_BYTE, NAK_BYTE};
  assign tx_valid  = 1'b0;
  assign tx_data   = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: vector table, corner sequences, random vs model.
module tb_uart_cmd_parser;
  localparam int unsigned T    = 40;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [7:0]  ACK  = 8'h06;
  localparam logic [7:0]  NAK  = 8'h15;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_data;
  logic        cmd_dat_update;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  uart_cmd_parser #(.SYNC_BYTE(SYNC), .TIMEOUT_CYC(T), .TO_W(6),
                    .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd_opcode(cmd_opcode), .cmd_data(cmd_data),
    .cmd_dat_update(cmd_dat_update), .err_cnt(err_cnt));

  int tests = 0;
  int fails = 0;

  // Reference model: frame kept as a byte list, idle = cycles since last accepted byte.
  logic [7:0]  frame[$];
  int          idle;
  logic        resp;
  logic [3:0]  m_opc;
  logic [15:0] m_data;
  logic        m_upd;
  int          m_err;
  logic        m_txv;
  logic [7:0]  m_txd;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void add_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d, input logic r, input logic txr);
    logic ok;
    if (r) begin
      frame.delete(); idle = 0; resp = 0;
      m_opc = 0; m_data = 0; m_upd = 0; m_err = 0; m_txv = 0; m_txd = 0;
      return;
    end
    m_upd = 0;
    if (resp) begin
      if (v) add_err();
      if (txr) begin resp = 0; m_txv = 0; end
    end else if (frame.size() > 0) begin
      if (idle == int'(T)) begin
        frame.delete(); idle = 0; add_err();
      end else if (v) begin
        frame.push_back(d); idle = 0;
        if (frame.size() == 5) begin
          ok = (frame[1][7:4] == 4'h0) && ((frame[1] ^ frame[2] ^ frame[3]) == frame[4]);
          if (ok) begin
            m_opc = frame[1][3:0]; m_data = {frame[2], frame[3]}; m_upd = 1;
          end else add_err();
`ifdef UART_CMD_ECHO_EN
          resp = 1; m_txv = 1; m_txd = ok ? ACK : NAK;
`endif
          frame.delete();
        end
      end else idle++;
    end else if (v && d == SYNC) begin
      frame.push_back(d); idle = 0;
    end
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic txr);
    rx_valid = v; rx_data = d; rst = r; tx_ready = txr;
    @(posedge clk);
    model_step(v, d, r, txr);
    #1;
    chk("m_opcode", 16'(cmd_opcode), 16'(m_opc));
    chk("m_data", cmd_data, m_data);
    chk("m_update", 16'(cmd_dat_update), 16'(m_upd));
    chk("m_err_cnt", 16'(err_cnt), 16'(m_err));
    chk("m_tx_valid", 16'(tx_valid), 16'(m_txv));
    if (m_txv) chk("m_tx_data", 16'(tx_data), 16'(m_txd));
    else chk("m_tx_data_idle", 16'(tx_valid ? tx_data : 8'h00), 16'h0000);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f, input int gap, input logic txr);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, f[39 - 8*i -: 8], 1'b0, txr);
      if (i < 4) repeat (gap) step(1'b0, 8'h00, 1'b0, txr);
    end
  endtask

  typedef struct {
    logic [39:0] frm;
    logic [3:0]  opc;
    logic [15:0] data;
    logic        upd;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs[6];
  int   err0;

  initial begin
    vecs[0] = '{40'hA5_03_12_34_25, 4'h3, 16'h1234, 1'b1, 8'd0};
    vecs[1] = '{40'hA5_03_12_34_00, 4'h3, 16'h1234, 1'b0, 8'd1};
    vecs[2] = '{40'hA5_05_00_01_04, 4'h5, 16'h0001, 1'b1, 8'd1};
    vecs[3] = '{40'hA5_F1_00_00_F1, 4'h5, 16'h0001, 1'b0, 8'd2};
    vecs[4] = '{40'hA5_0A_BE_EF_5B, 4'hA, 16'hBEEF, 1'b1, 8'd2};
    vecs[5] = '{40'hA5_00_A5_A5_00, 4'h0, 16'hA5A5, 1'b1, 8'd2};

    rx_valid = 0; rx_data = 0; rst = 1; tx_ready = 0;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("reset_opcode", 16'(cmd_opcode), 16'h0);
    chk("reset_data", cmd_data, 16'h0);
    chk("reset_update", 16'(cmd_dat_update), 16'h0);
    chk("reset_err", 16'(err_cnt), 16'h0);
    chk("reset_tx_valid", 16'(tx_valid), 16'h0);
    chk("reset_tx_data", 16'(tx_data), 16'h0);

    // Garbage in IDLE is silently ignored.
    step(1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b1);
    chk("garbage_err", 16'(err_cnt), 16'h0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].frm, 1, 1'b1);
      chk("vec_update", 16'(cmd_dat_update), 16'(vecs[i].upd));
      chk("vec_opcode", 16'(cmd_opcode), 16'(vecs[i].opc));
      chk("vec_data", cmd_data, vecs[i].data);
      chk("vec_err", 16'(err_cnt), 16'(vecs[i].err));
`ifdef UART_CMD_ECHO_EN
      chk("vec_tx_valid", 16'(tx_valid), 16'h1);
      chk("vec_tx_data", 16'(tx_data), vecs[i].upd ? 16'(ACK) : 16'(NAK));
`endif
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("vec_strobe_1cyc", 16'(cmd_dat_update), 16'h0);
    end

    // Stall after A5 03 until timeout, then a good frame.
    err0 = int'(err_cnt);
    step(1'b1, SYNC, 1'b0, 1'b1);
    step(1'b1, 8'h03, 1'b0, 1'b1);
    repeat (T + 2) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("timeout_err", 16'(err_cnt), 16'(err0 + 1));
    send_frame(40'hA5_05_00_01_04, 0, 1'b1);
    chk("after_to_opcode", 16'(cmd_opcode), 16'h5);
    chk("after_to_data", cmd_data, 16'h0001);
    step(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef UART_CMD_ECHO_EN
    // Response held while tx_ready stays low; bytes in RESP count as errors.
    err0 = int'(err_cnt);
    send_frame(40'hA5_03_12_34_25, 0, 1'b0);
    for (int c = 0; c < 50; c++) begin
      step(c == 10 || c == 30, (c == 10) ? SYNC : 8'h03, 1'b0, 1'b0);
      chk("hold_tx_valid", 16'(tx_valid), 16'h1);
      chk("hold_tx_data", 16'(tx_data), 16'(ACK));
    end
    chk("resp_err", 16'(err_cnt), 16'(err0 + 2));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("resp_release", 16'(tx_valid), 16'h0);
    send_frame(40'hA5_0A_BE_EF_5B, 0, 1'b1);
    chk("resp_idle_frame", cmd_data, 16'hBEEF);
    step(1'b0, 8'h00, 1'b0, 1'b1);
`endif

    // Reset during DHI, then a good frame decodes normally.
    step(1'b1, SYNC, 1'b0, 1'b1);
    step(1'b1, 8'h07, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("midrst_opcode", 16'(cmd_opcode), 16'h0);
    chk("midrst_data", cmd_data, 16'h0);
    chk("midrst_err", 16'(err_cnt), 16'h0);
    send_frame(40'hA5_03_12_34_25, 0, 1'b1);
    chk("midrst_frame_opc", 16'(cmd_opcode), 16'h3);
    chk("midrst_frame_data", cmd_data, 16'h1234);
    chk("midrst_frame_upd", 16'(cmd_dat_update), 16'h1);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int kind, gsel, nb;
      logic [7:0] fb[5];
      kind = int'($urandom_range(0, 11));
      if (kind == 0) step(1'b1, 8'($urandom), 1'b0, ($urandom_range(0, 3) != 0));
      else if (kind == 1) step(1'b0, 8'h00, ($urandom_range(0, 3) == 0), 1'b1);
      else begin
        fb[0] = SYNC;
        fb[1] = (kind == 2) ? 8'($urandom) : {4'h0, 4'($urandom)};
        fb[2] = 8'($urandom);
        fb[3] = 8'($urandom);
        fb[4] = fb[1] ^ fb[2] ^ fb[3];
        if (kind == 3) fb[4] = fb[4] ^ 8'($urandom_range(1, 255));
        nb = (kind == 5) ? int'($urandom_range(1, 4)) : 5;
        gsel = int'($urandom_range(0, 3));
        for (int i = 0; i < nb; i++) begin
          step(1'b1, fb[i], 1'b0, ($urandom_range(0, 3) != 0));
          if (i < nb - 1) begin
            if (kind == 4 && i == 1) repeat (int'(T) - 2 + gsel) step(1'b0, 8'h00, 1'b0, 1'b1);
            else repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, 1'b0, ($urandom_range(0, 3) != 0));
          end
        end
        repeat ($urandom_range(0, 3)) step(1'b0, 8'h00, 1'b0, ($urandom_range(0, 3) != 0));
      end
    end
    repeat (T + 4) step(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
